// File: rtl/peripheral_pkg.sv
// Shared constants and types for the peripheral block: page bases and
// the irq_controller register offsets (word index, data_addr[11:2]).
package peripheral_pkg;

    typedef logic [4:0] irq_id_t;

    localparam logic [19:0] TIMER32_BASE_ADDR = 20'h00021;
    localparam logic [19:0] IRQC_BASE_ADDR    = 20'h00022;

    localparam logic [9:0] IRQC_REG_PENDING = 10'd0;
    localparam logic [9:0] IRQC_REG_ENABLE  = 10'd1;
    localparam logic [9:0] IRQC_REG_MODE    = 10'd2;
    localparam logic [9:0] IRQC_REG_CLEAR   = 10'd3;
    localparam logic [9:0] IRQC_REG_CLAIM   = 10'd4;
    localparam logic [9:0] IRQC_REG_GIE     = 10'd5;

endpackage

// File: rtl/irq_controller_if.sv
// req/gnt/rvalid data bus shared by the peripherals.
interface irq_controller_if;

    logic        data_req;
    logic        data_we;
    logic [3:0]  data_be;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_gnt;
    logic        data_rvalid;
    logic [31:0] data_rdata;

    modport master (
        output data_req, data_we, data_be, data_addr, data_wdata,
        input  data_gnt, data_rvalid, data_rdata
    );

    modport slave (
        input  data_req, data_we, data_be, data_addr, data_wdata,
        output data_gnt, data_rvalid, data_rdata
    );

endinterface

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: the lowest set index of active wins.
// id is 0 when nothing is active.
module irq_prio_enc
    import peripheral_pkg::*;
#(
    parameter int NUM_IRQ = 8
) (
    input  logic [NUM_IRQ-1:0] active,
    output logic               valid,
    output irq_id_t            id
);

    // Scan from the top down so the lowest set index is the last to write.
    always_comb begin
        valid = 1'b0;
        id    = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (active[i]) begin
                valid = 1'b1;
                id    = irq_id_t'(i);
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: latches/masks peripheral irq lines and presents one
// prioritized request plus id to the core. Bus slave on the data bus.
module irq_controller
    import peripheral_pkg::*;
#(
    parameter int          NUM_IRQ   = 8,
    parameter logic [19:0] BASE_ADDR = IRQC_BASE_ADDR
) (
    input  logic               clk,
    input  logic               rst,
    irq_controller_if.slave    bus,
    input  logic [NUM_IRQ-1:0] irq_src,
    output logic               irq_out,
    output irq_id_t            irq_id
);

    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] enable;
    logic [NUM_IRQ-1:0] mode;
    logic [NUM_IRQ-1:0] src_prev;
    logic [NUM_IRQ-1:0] active;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] wr_mask;
    logic [NUM_IRQ-1:0] wr_data;
    logic [NUM_IRQ-1:0] clr_set;
    logic               gie;
    logic               decode;
    logic               accept;
    logic               wr_acc;
    logic               rd_acc;
    logic               prio_valid;
    irq_id_t            prio_id;
    logic [9:0]         reg_off;
    logic [31:0]        be_mask;
    logic [31:0]        rd_value;
    logic               unused_bits;

    // gnt blocks the cycle after an accept, so a held req is taken every 2nd cycle.
    assign decode  = (bus.data_addr[31:12] == BASE_ADDR);
    assign accept  = bus.data_req & decode & ~bus.data_gnt;
    assign wr_acc  = accept & bus.data_we;
    assign rd_acc  = accept & ~bus.data_we;
    assign reg_off = bus.data_addr[11:2];

    assign wr_mask = be_mask[NUM_IRQ-1:0];
    assign wr_data = bus.data_wdata[NUM_IRQ-1:0];

    // Bits beyond NUM_IRQ and the byte offset carry no state.
    assign unused_bits = ^{be_mask, bus.data_wdata, bus.data_addr[1:0]};

    assign active = pending & enable;
    assign rise   = irq_src & ~src_prev;

    irq_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_prio (
        .active (active),
        .valid  (prio_valid),
        .id     (prio_id)
    );

    // Expand byte enables to a bit mask.
    always_comb begin
        be_mask = '0;
        for (int b = 0; b < 4; b++) begin
            be_mask[b*8 +: 8] = {8{bus.data_be[b]}};
        end
    end

    // Edge-pending clears from a CLEAR write or a successful CLAIM read.
    always_comb begin
        clr_set = '0;
        if (wr_acc && reg_off == IRQC_REG_CLEAR) begin
            clr_set = wr_data & wr_mask;
        end
        if (rd_acc && reg_off == IRQC_REG_CLAIM && prio_valid) begin
            for (int i = 0; i < NUM_IRQ; i++) begin
                if (prio_id == irq_id_t'(i)) clr_set[i] = 1'b1;
            end
        end
    end

    // Read mux; unmapped offsets and bits above NUM_IRQ read as 0.
    always_comb begin
        rd_value = '0;
        case (reg_off)
            IRQC_REG_PENDING: rd_value[NUM_IRQ-1:0] = pending;
            IRQC_REG_ENABLE:  rd_value[NUM_IRQ-1:0] = enable;
            IRQC_REG_MODE:    rd_value[NUM_IRQ-1:0] = mode;
            IRQC_REG_CLAIM:   rd_value = {prio_valid, 26'b0, prio_id};
            IRQC_REG_GIE:     rd_value[0] = gie;
            default:          rd_value = '0;
        endcase
    end

    // Bus handshake and read-data capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.data_gnt    <= 1'b0;
            bus.data_rvalid <= 1'b0;
            bus.data_rdata  <= '0;
        end else begin
            bus.data_gnt    <= accept;
            bus.data_rvalid <= bus.data_gnt;
            if (rd_acc) bus.data_rdata <= rd_value;
        end
    end

    // Configuration registers with byte-enable merge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enable <= '0;
            mode   <= '0;
            gie    <= 1'b0;
        end else if (wr_acc) begin
            case (reg_off)
                IRQC_REG_ENABLE: enable <= (enable & ~wr_mask) | (wr_data & wr_mask);
                IRQC_REG_MODE:   mode   <= (mode & ~wr_mask) | (wr_data & wr_mask);
                IRQC_REG_GIE:    if (bus.data_be[0]) gie <= bus.data_wdata[0];
                default:         ;
            endcase
        end
    end

    // Edge lines are sticky (a rise beats a same-cycle clear); level lines track the source.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_prev <= '0;
            pending  <= '0;
        end else begin
            src_prev <= irq_src;
            pending  <= (mode & (rise | (pending & ~clr_set))) | (~mode & irq_src);
        end
    end

    // Registered request and id to the core.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_out <= 1'b0;
            irq_id  <= '0;
        end else begin
            irq_out <= gie & prio_valid;
            irq_id  <= prio_id;
        end
    end

endmodule
